stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control FSM and BCD time accumulator for the stopwatch.
- Sequences the centisecond tick generator: gates it on and off, and clears its phase.
- Counts the 10 ms tick pulses into MM:SS.CC in BCD.
- Handles start/stop/lap/reset from two debounced one-cycle button pulses.
- Drives the display-side BCD outputs.

Parameters:
MIN_LIMIT, 59, highest minute value (binary); must be ≤ 99; minutes wrap or saturate after this value.

Ports:
clk  in  1  system clock, same domain as the tick generator
rst_n  in  1  asynchronous active-low reset
ss_pulse  in  1  start/stop button, one-cycle pulse, already debounced and synchronised
lr_pulse  in  1  lap/reset button, one-cycle pulse, already debounced and synchronised
tick  in  1  one-cycle pulse every 10 ms from the tick generator
div_en  out  1  enable to the tick generator; its count holds while low
div_clr  out  1  one-cycle synchronous clear of the tick generator count
disp_min  out  8  BCD minutes {tens,ones}
disp_sec  out  8  BCD seconds {tens,ones}
disp_cs  out  8  BCD centiseconds {tens,ones}
running  out  1  high in RUN and LAP
lap_active  out  1  high in LAP (display frozen)
overflow  out  1  see Behaviour / Optional Feature

Behaviour:
- All outputs registered.
- Reset (async, rst_n=0):
  - State IDLE.
  - Live counter and lap register = 00:00.00.
  - div_en=0, div_clr=0, running=0, lap_active=0, overflow=0.
- States:
  - IDLE: counter zero; div_en=0.
  - RUN: div_en=1; display shows live counter.
  - LAP: div_en=1; counting continues; display shows lap register.
  - PAUSE: div_en=0; counter holds.
- Transitions, evaluated on each clk edge:
  - IDLE + ss → RUN; div_clr=1 for that one cycle so the first tick comes a full 10 ms later.
  - IDLE + lr → stay IDLE.
  - RUN + ss → PAUSE.
  - RUN + lr → LAP; lap register ← live counter value *after* any same-cycle tick increment.
  - LAP + lr → RUN; display returns to live.
  - LAP + ss → PAUSE; lap released, display live.
  - PAUSE + ss → RUN; no div_clr, so the partial tick phase is preserved.
  - PAUSE + lr → IDLE; counter and lap register cleared, div_clr=1 for one cycle, overflow cleared.
- ss and lr in the same cycle: ss wins, lr ignored.
- Counting:
  - A tick is counted iff the current (pre-edge) state is RUN or LAP, including the cycle in which ss moves the FSM to PAUSE.
  - Ticks in IDLE or PAUSE are ignored.
  - Counter updates on the edge after tick is sampled high; display reflects it with 1-cycle latency.
- BCD arithmetic, each digit 4 bits, never outside its range:
  - cs ones 9→0 carries into cs tens.
  - cs tens 9→0 carries into sec ones.
  - sec ones 9→0 carries into sec tens.
  - sec tens 5→0 carries into minutes.
  - Minutes are stored as BCD and count to MIN_LIMIT.
- Minute limit (default build): at MIN_LIMIT:59.99 the next tick wraps to 00:00.00 and overflow pulses high for exactly one cycle.
- Lap register is untouched by counting; it is updated only on the RUN→LAP transition.
- rst_n asserted mid-count: immediate return to reset values; no div_clr pulse is generated.

Optional Feature:
- Macro: STOPWATCH_SATURATE_EN
- Defined:
  - Counter saturates at MIN_LIMIT:59.99; further ticks are ignored.
  - overflow is sticky high until PAUSE+lr → IDLE or reset.
  - FSM state and div_en are unaffected.
- Undefined: wrap to 00:00.00 with a one-cycle overflow pulse, as in Behaviour.

Test Plan:
- Reset, then ss, then 150 ticks → div_clr high exactly one cycle after ss; running=1; display 00:01.50.
- RUN at 00:00.37, ss → PAUSE, div_en=0; 20 ticks ignored, display stays 00:00.37. Then ss → RUN, one tick → 00:00.38.
- RUN at 00:12.40, lr → lap_active=1, display frozen at 00:12.40; 60 more ticks. Then lr → display 00:13.00 live.
- ss and lr in the same cycle during RUN → PAUSE entered, lap_active stays 0. Then lr → IDLE, display 00:00.00, div_clr pulse.
- Preload to 59:59.99, one tick:
  - Default build → 00:00.00 with a one-cycle overflow pulse.
  - STOPWATCH_SATURATE_EN build → holds 59:59.99, overflow stays 1 until PAUSE+lr.
- In RUN at 00:00.09 with tick high, assert rst_n=0 mid-cycle → outputs zero immediately, state IDLE; tick after release ignored.

Source files
------------

// File: rtl/stopwatch_if.sv
// Stopwatch control bundle: button/tick inputs and display/tick-generator outputs.
interface stopwatch_if;
    logic       ss_pulse;
    logic       lr_pulse;
    logic       tick;
    logic       div_en;
    logic       div_clr;
    logic [7:0] disp_min;
    logic [7:0] disp_sec;
    logic [7:0] disp_cs;
    logic       running;
    logic       lap_active;
    logic       overflow;

    // Driver side (buttons, tick generator, display consumer)
    modport master (
        output ss_pulse, lr_pulse, tick,
        input  div_en, div_clr, disp_min, disp_sec, disp_cs,
        input  running, lap_active, overflow
    );

    // Controller side
    modport slave (
        input  ss_pulse, lr_pulse, tick,
        output div_en, div_clr, disp_min, disp_sec, disp_cs,
        output running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM and MM:SS.CC BCD accumulator.
// Optional macro STOPWATCH_SATURATE_EN: saturate at MIN_LIMIT:59.99 with a
// sticky overflow flag instead of wrapping with a one-cycle overflow pulse.
module stopwatch_ctrl #(
    parameter int unsigned MIN_LIMIT = 59
) (
    input  logic           clk,
    input  logic           rst_n,
    stopwatch_if.slave     sw
);

    localparam int unsigned TIME_W = 24;
    localparam logic [7:0] MIN_BCD = {4'(MIN_LIMIT / 10), 4'(MIN_LIMIT % 10)};
    localparam logic [TIME_W-1:0] MAX_VAL = {MIN_BCD, 8'h59, 8'h99};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [TIME_W-1:0] live_q, live_d;
    logic [TIME_W-1:0] lap_q, lap_d;
    logic [TIME_W-1:0] disp_q, disp_d;
    logic              div_en_q, div_en_d;
    logic              div_clr_q, div_clr_d;
    logic              running_q, running_d;
    logic              lap_active_q, lap_active_d;
    logic              overflow_q, overflow_d;

    logic [TIME_W-1:0] inc_val;
    logic              at_max;
    logic              cnt_en;

    // BCD +1 with ripple carry through cs, seconds and minutes digits
    always_comb begin : bcd_inc
        logic carry;
        inc_val = live_q;
        carry   = 1'b1;
        if (live_q[3:0] == 4'd9) inc_val[3:0] = 4'd0;
        else begin inc_val[3:0] = live_q[3:0] + 4'd1; carry = 1'b0; end
        if (carry) begin
            if (live_q[7:4] == 4'd9) inc_val[7:4] = 4'd0;
            else begin inc_val[7:4] = live_q[7:4] + 4'd1; carry = 1'b0; end
        end
        if (carry) begin
            if (live_q[11:8] == 4'd9) inc_val[11:8] = 4'd0;
            else begin inc_val[11:8] = live_q[11:8] + 4'd1; carry = 1'b0; end
        end
        if (carry) begin
            if (live_q[15:12] == 4'd5) inc_val[15:12] = 4'd0;
            else begin inc_val[15:12] = live_q[15:12] + 4'd1; carry = 1'b0; end
        end
        if (carry) begin
            if (live_q[19:16] == 4'd9) inc_val[19:16] = 4'd0;
            else begin inc_val[19:16] = live_q[19:16] + 4'd1; carry = 1'b0; end
        end
        if (carry) begin
            if (live_q[23:20] == 4'd9) inc_val[23:20] = 4'd0;
            else inc_val[23:20] = live_q[23:20] + 4'd1;
        end
        at_max = (live_q == MAX_VAL);
    end

    // Next-state, counter, lap capture and output decode
    always_comb begin : next_state
        state_d   = state_q;
        live_d    = live_q;
        lap_d     = lap_q;
        div_clr_d = 1'b0;
`ifdef STOPWATCH_SATURATE_EN
        overflow_d = overflow_q;
`else
        overflow_d = 1'b0;
`endif
        cnt_en = ((state_q == RUN) || (state_q == LAP)) && sw.tick;

        // Tick counted before the FSM decision so lap capture sees the new value
        if (cnt_en) begin
            if (at_max) begin
`ifdef STOPWATCH_SATURATE_EN
                overflow_d = 1'b1;
`else
                live_d     = '0;
                overflow_d = 1'b1;
`endif
            end else begin
                live_d = inc_val;
            end
        end

        // ss has priority over lr in every state
        unique case (state_q)
            IDLE: begin
                if (sw.ss_pulse) begin
                    state_d   = RUN;
                    div_clr_d = 1'b1;
                end
            end
            RUN: begin
                if (sw.ss_pulse) state_d = PAUSE;
                else if (sw.lr_pulse) begin
                    state_d = LAP;
                    lap_d   = live_d;
                end
            end
            LAP: begin
                if (sw.ss_pulse)      state_d = PAUSE;
                else if (sw.lr_pulse) state_d = RUN;
            end
            PAUSE: begin
                if (sw.ss_pulse) state_d = RUN;
                else if (sw.lr_pulse) begin
                    state_d    = IDLE;
                    live_d     = '0;
                    lap_d      = '0;
                    div_clr_d  = 1'b1;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        div_en_d     = (state_d == RUN) || (state_d == LAP);
        running_d    = div_en_d;
        lap_active_d = (state_d == LAP);
        disp_d       = (state_d == LAP) ? lap_d : live_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            live_q       <= '0;
            lap_q        <= '0;
            disp_q       <= '0;
            div_en_q     <= 1'b0;
            div_clr_q    <= 1'b0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            live_q       <= live_d;
            lap_q        <= lap_d;
            disp_q       <= disp_d;
            div_en_q     <= div_en_d;
            div_clr_q    <= div_clr_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
        end
    end

    assign sw.div_en     = div_en_q;
    assign sw.div_clr    = div_clr_q;
    assign sw.running    = running_q;
    assign sw.lap_active = lap_active_q;
    assign sw.overflow   = overflow_q;
    assign sw.disp_min   = disp_q[23:16];
    assign sw.disp_sec   = disp_q[15:8];
    assign sw.disp_cs    = disp_q[7:0];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (MIN_LIMIT=1 keeps the rollover test short).
module tb_stopwatch_ctrl;

    localparam int unsigned TB_MIN = 1;
    localparam int MAXT = (TB_MIN + 1) * 6000 - 1;
    localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_PAUSE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] exp_q[$];

    int   m_state, m_live, m_lap;
    logic m_ovf, m_clr;

    stopwatch_if sw_if();

    stopwatch_ctrl #(.MIN_LIMIT(TB_MIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] to_disp(input int t);
        return {bcd8(t / 6000), bcd8((t / 100) % 60), bcd8(t % 100)};
    endfunction

    function automatic logic [31:0] model_out();
        logic [23:0] d;
        logic en;
        d  = (m_state == S_LAP) ? to_disp(m_lap) : to_disp(m_live);
        en = (m_state == S_RUN) || (m_state == S_LAP);
        return {3'b000, d, en, m_clr, en, (m_state == S_LAP), m_ovf};
    endfunction

    function automatic logic [31:0] dut_out();
        return {3'b000, sw_if.disp_min, sw_if.disp_sec, sw_if.disp_cs, sw_if.div_en,
                sw_if.div_clr, sw_if.running, sw_if.lap_active, sw_if.overflow};
    endfunction

    function automatic logic [31:0] disp_now();
        return {8'h00, sw_if.disp_min, sw_if.disp_sec, sw_if.disp_cs};
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_live = 0; m_lap = 0; m_ovf = 1'b0; m_clr = 1'b0;
    endtask

    task automatic model_step(input logic ss, input logic lr, input logic tk);
        int   nlive;
        logic novf;
        nlive = m_live;
`ifdef STOPWATCH_SATURATE_EN
        novf = m_ovf;
`else
        novf = 1'b0;
`endif
        m_clr = 1'b0;
        if (((m_state == S_RUN) || (m_state == S_LAP)) && tk) begin
            if (m_live == MAXT) begin
`ifndef STOPWATCH_SATURATE_EN
                nlive = 0;
`endif
                novf = 1'b1;
            end else begin
                nlive = m_live + 1;
            end
        end
        case (m_state)
            S_IDLE:  if (ss) begin m_state = S_RUN; m_clr = 1'b1; end
            S_RUN:   if (ss) m_state = S_PAUSE;
                     else if (lr) begin m_state = S_LAP; m_lap = nlive; end
            S_LAP:   if (ss) m_state = S_PAUSE; else if (lr) m_state = S_RUN;
            default: if (ss) m_state = S_RUN;
                     else if (lr) begin
                         m_state = S_IDLE; nlive = 0; m_lap = 0; m_clr = 1'b1; novf = 1'b0;
                     end
        endcase
        m_live = nlive;
        m_ovf  = novf;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, dut_out(), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check(tag, dut_out(), e);
        end
    endtask

    // One clock: drive, predict, push, then compare just after the edge
    task automatic step(input logic ss, input logic lr, input logic tk);
        sw_if.ss_pulse = ss;
        sw_if.lr_pulse = lr;
        sw_if.tick     = tk;
        model_step(ss, lr, tk);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        pop_check("cyc");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        sw_if.ss_pulse = 1'b0;
        sw_if.lr_pulse = 1'b0;
        sw_if.tick     = 1'b0;
        model_reset();

        // Reset state
        #12;
        exp_q.push_back(model_out());
        pop_check("reset");
        check("reset_raw", dut_out(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start, then 150 ticks
        step(1'b1, 1'b0, 1'b0);
        check("start_clr", {31'h0, sw_if.div_clr}, 32'h1);
        check("start_run", {31'h0, sw_if.running}, 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check("clr_one", {31'h0, sw_if.div_clr}, 32'h0);
        ticks(150);
        check("disp_150", disp_now(), 32'h0000_0150);

        // Back to IDLE, then pause/resume at 00:00.37 (tick in the ss cycle counts)
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("idle_disp", disp_now(), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        ticks(36);
        step(1'b1, 1'b0, 1'b1);
        check("pause_en", {31'h0, sw_if.div_en}, 32'h0);
        ticks(20);
        check("pause_hold", disp_now(), 32'h0000_0037);
        step(1'b1, 1'b0, 1'b0);
        ticks(1);
        check("resume_38", disp_now(), 32'h0000_0038);

        // Lap at 00:12.40 (captured with same-cycle tick), 60 ticks frozen, release
        ticks(1201);
        step(1'b0, 1'b1, 1'b1);
        check("lap_act", {31'h0, sw_if.lap_active}, 32'h1);
        check("lap_disp", disp_now(), 32'h0000_1240);
        ticks(60);
        check("lap_frozen", disp_now(), 32'h0000_1240);
        step(1'b0, 1'b1, 1'b0);
        check("lap_live", disp_now(), 32'h0000_1300);

        // ss and lr together: ss wins
        step(1'b1, 1'b1, 1'b0);
        check("both_lap", {31'h0, sw_if.lap_active}, 32'h0);
        check("both_run", {31'h0, sw_if.running}, 32'h0);
        step(1'b0, 1'b1, 1'b0);
        check("to_idle_disp", disp_now(), 32'h0);
        check("to_idle_clr", {31'h0, sw_if.div_clr}, 32'h1);

        // Run to the top of the range, then one more tick
        step(1'b1, 1'b0, 1'b0);
        ticks(MAXT);
        check("at_max", disp_now(), 32'h0001_5999);
        ticks(1);
`ifdef STOPWATCH_SATURATE_EN
        check("sat_disp", disp_now(), 32'h0001_5999);
        check("sat_ovf", {31'h0, sw_if.overflow}, 32'h1);
        ticks(3);
        check("sat_hold", disp_now(), 32'h0001_5999);
        check("sat_sticky", {31'h0, sw_if.overflow}, 32'h1);
        check("sat_run", {31'h0, sw_if.div_en}, 32'h1);
`else
        check("wrap_disp", disp_now(), 32'h0);
        check("wrap_ovf", {31'h0, sw_if.overflow}, 32'h1);
        ticks(1);
        check("wrap_ovf_pulse", {31'h0, sw_if.overflow}, 32'h0);
        check("wrap_next", disp_now(), 32'h0000_0001);
`endif
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("ovf_clear", {31'h0, sw_if.overflow}, 32'h0);

        // Async reset mid-cycle while ticking
        step(1'b1, 1'b0, 1'b0);
        ticks(9);
        check("pre_rst", disp_now(), 32'h0000_0009);
        sw_if.tick = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_out());
        pop_check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        ticks(1);
        check("post_rst_disp", disp_now(), 32'h0);
        check("post_rst_clr", {31'h0, sw_if.div_clr}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
